txn_arbiter: RTL and testbench

- Shares the single memory transaction port (req / rdy / addr / wdata / rdata) between two masters.
- Port 0 is the fabric map-load / dir-pack engine; port 1 is the CPU-side DMA / debug master.
- Requesters fire one-cycle requests and then wait for a one-cycle ready.
- The arbiter latches each request, grants round-robin, keeps one transaction in flight, returns the read data to the owner, and times out a hung memory.

---
 rtl/txn_arbiter.sv | 176 +++++++++++++++++
 tb/tb_txn_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/txn_arbiter.sv
// Two-master round-robin arbiter for a single one-in-flight memory transaction port.
// Latches one-cycle requests, issues them in turn, routes completions and times out a stalled memory.
module txn_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        r0_req,
   input  logic        r0_wr,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   output logic        r0_rdy,
   output logic [31:0] r0_rdata,
   input  logic        r1_req,
   input  logic        r1_wr,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   output logic        r1_rdy,
   output logic [31:0] r1_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_rdy,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        err_timeout,
   output logic [1:0]  overrun
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TW = 16;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   state_t        r_state, w_state_nx;
   logic [1:0]    r_pend, w_pend_nx;
   logic          r_last, w_last_nx;
   logic          r_owner, w_owner_nx;
   logic [TW-1:0] r_timer, w_timer_nx;
   txn_t          r_txn [2];
   txn_t          w_txn_nx [2];
   txn_t          w_in_txn [2];
   logic [1:0]    w_req_in;
   logic          w_grant;

   logic          r_mem_req, w_mem_req_nx;
   txn_t          r_mem, w_mem_nx;
   logic [1:0]    r_rdy, w_rdy_nx;
   logic [DW-1:0] r_rdata [2];
   logic [DW-1:0] w_rdata_nx [2];
   logic          r_err, w_err_nx;
   logic [1:0]    r_overrun, w_overrun_nx;
   logic          r_busy, w_busy_nx;

   assign w_req_in    = {r1_req, r0_req};
   assign w_in_txn[0] = {r0_wr, r0_addr, r0_wdata};
   assign w_in_txn[1] = {r1_wr, r1_addr, r1_wdata};

   // Next-state, request capture, grant and completion routing
   always_comb begin
      w_state_nx    = r_state;
      w_pend_nx     = r_pend;
      w_last_nx     = r_last;
      w_owner_nx    = r_owner;
      w_timer_nx    = r_timer;
      w_txn_nx      = r_txn;
      w_mem_req_nx  = 1'b0;
      w_mem_nx      = r_mem;
      w_rdy_nx      = 2'b00;
      w_rdata_nx    = r_rdata;
      w_err_nx      = 1'b0;
      w_overrun_nx  = r_overrun;
      w_grant       = 1'b0;

      // A port already queued or in flight drops the new request and flags it
      for (int n = 0; n < 2; n++) begin
         if (w_req_in[n]) begin
            if (r_pend[n] || (r_state == S_WAIT && r_owner == 1'(n))) begin
               w_overrun_nx[n] = 1'b1;
            end else begin
               w_pend_nx[n] = 1'b1;
               w_txn_nx[n]  = w_in_txn[n];
            end
         end
      end

      case (r_state)
         S_IDLE: begin
            if (|r_pend) begin
               w_grant            = (r_pend == 2'b11) ? ~r_last : r_pend[1];
               w_owner_nx         = w_grant;
               w_last_nx          = w_grant;
               w_pend_nx[w_grant] = 1'b0;
               w_mem_req_nx       = 1'b1;
               w_mem_nx           = r_txn[w_grant];
               w_timer_nx         = '0;
               w_state_nx         = S_WAIT;
            end
         end
         S_WAIT: begin
            w_timer_nx = (r_timer == TMO_MAX) ? r_timer : r_timer + TW'(1);
            if (mem_rdy) begin
               w_rdy_nx[r_owner]   = 1'b1;
               w_rdata_nx[r_owner] = mem_rdata;
               w_state_nx          = S_IDLE;
            end else if (r_timer == TMO_LAST) begin
               w_rdy_nx[r_owner]   = 1'b1;
               w_rdata_nx[r_owner] = ERR_DATA;
               w_err_nx            = 1'b1;
               w_state_nx          = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      w_busy_nx = (w_state_nx != S_IDLE) || (|w_pend_nx);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state    <= S_IDLE;
         r_pend     <= 2'b00;
         r_last     <= 1'b1;
         r_owner    <= 1'b0;
         r_timer    <= '0;
         r_txn[0]   <= '0;
         r_txn[1]   <= '0;
         r_mem_req  <= 1'b0;
         r_mem      <= '0;
         r_rdy      <= 2'b00;
         r_rdata[0] <= '0;
         r_rdata[1] <= '0;
         r_err      <= 1'b0;
         r_overrun  <= 2'b00;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_pend     <= w_pend_nx;
         r_last     <= w_last_nx;
         r_owner    <= w_owner_nx;
         r_timer    <= w_timer_nx;
         r_txn      <= w_txn_nx;
         r_mem_req  <= w_mem_req_nx;
         r_mem      <= w_mem_nx;
         r_rdy      <= w_rdy_nx;
         r_rdata    <= w_rdata_nx;
         r_err      <= w_err_nx;
         r_overrun  <= w_overrun_nx;
         r_busy     <= w_busy_nx;
      end
   end

   assign r0_rdy      = r_rdy[0];
   assign r1_rdy      = r_rdy[1];
   assign r0_rdata    = r_rdata[0];
   assign r1_rdata    = r_rdata[1];
   assign mem_req     = r_mem_req;
   assign mem_wr      = r_mem.wr;
   assign mem_addr    = r_mem.addr;
   assign mem_wdata   = r_mem.wdata;
   assign busy        = r_busy;
   assign err_timeout = r_err;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_txn_arbiter.sv
// Directed bench for txn_arbiter: latency, round-robin order, timeout, overrun and mid-flight reset.
module tb_txn_arbiter;

   logic        clk = 1'b0;
   logic        arst;
   logic        r0_req, r0_wr, r1_req, r1_wr;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_rdy, r1_rdy;
   logic [31:0] r0_rdata, r1_rdata;
   logic        mem_req, mem_wr, mem_rdy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        busy, err_timeout;
   logic [1:0]  overrun;

   int n_chk  = 0;
   int n_pass = 0;

   txn_arbiter #(.TIMEOUT_CYC(4), .ERR_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .arst(arst),
      .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_rdy(r0_rdy), .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_rdy(r1_rdy), .r1_rdata(r1_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
      .busy(busy), .err_timeout(err_timeout), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic clr_inputs();
      r0_req = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_wdata = '0;
      mem_rdy = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      clr_inputs();
      arst = 1'b1;
      step();
      step();
      arst = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int grants;
      int exp_port;
      int loops;

      // Reset values
      do_reset();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_r0_rdy", 32'(r0_rdy), 32'd0);
      chk("rst_r1_rdy", 32'(r1_rdy), 32'd0);
      chk("rst_r0_rdata", r0_rdata, 32'd0);
      chk("rst_r1_rdata", r1_rdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);

      // 1. Single read, memory answers in the 3rd WAIT cycle
      r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 32'h4000_0004;
      step();                                   // cycle 1
      r0_req = 1'b0;
      chk("t1_c1_mem_req", 32'(mem_req), 32'd0);
      chk("t1_c1_busy", 32'(busy), 32'd1);
      step();                                   // cycle 2
      chk("t1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h4000_0004);
      chk("t1_mem_wr", 32'(mem_wr), 32'd0);
      step();                                   // cycle 3
      chk("t1_c3_mem_req", 32'(mem_req), 32'd0);
      step();                                   // cycle 4
      chk("t1_c4_r0_rdy", 32'(r0_rdy), 32'd0);
      mem_rdy = 1'b1; mem_rdata = 32'h1234_5678;
      step();                                   // cycle 5
      mem_rdy = 1'b0;
      chk("t1_r0_rdy", 32'(r0_rdy), 32'd1);
      chk("t1_r0_rdata", r0_rdata, 32'h1234_5678);
      chk("t1_r1_rdy", 32'(r1_rdy), 32'd0);
      chk("t1_busy_done", 32'(busy), 32'd0);
      step();                                   // cycle 6
      chk("t1_r0_rdy_once", 32'(r0_rdy), 32'd0);
      chk("t1_r0_rdata_hold", r0_rdata, 32'h1234_5678);

      // 2. Simultaneous requests from reset: port 0 then port 1
      do_reset();
      r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 32'h4000_0000;
      r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 32'h4000_2000; r1_wdata = 32'hAABB_CCDD;
      step();
      r0_req = 1'b0; r1_req = 1'b0;
      step();
      chk("t2_mem_req0", 32'(mem_req), 32'd1);
      chk("t2_addr0", mem_addr, 32'h4000_0000);
      chk("t2_wr0", 32'(mem_wr), 32'd0);
      mem_rdy = 1'b1; mem_rdata = 32'h1111_1111;
      step();
      mem_rdy = 1'b0;
      chk("t2_r0_rdy", 32'(r0_rdy), 32'd1);
      chk("t2_r0_rdata", r0_rdata, 32'h1111_1111);
      chk("t2_r1_rdy_early", 32'(r1_rdy), 32'd0);
      chk("t2_busy_mid", 32'(busy), 32'd1);
      step();
      chk("t2_mem_req1", 32'(mem_req), 32'd1);
      chk("t2_addr1", mem_addr, 32'h4000_2000);
      chk("t2_wr1", 32'(mem_wr), 32'd1);
      chk("t2_wdata1", mem_wdata, 32'hAABB_CCDD);
      mem_rdy = 1'b1; mem_rdata = 32'h2222_2222;
      step();
      mem_rdy = 1'b0;
      chk("t2_r1_rdy", 32'(r1_rdy), 32'd1);
      chk("t2_r1_rdata", r1_rdata, 32'h2222_2222);
      chk("t2_r0_rdy_once", 32'(r0_rdy), 32'd0);
      chk("t2_busy_end", 32'(busy), 32'd0);

      // 3. Fairness: each port re-requests on its rdy; grants must alternate
      do_reset();
      r0_req = 1'b1; r0_addr = 32'h4000_0100;
      r1_req = 1'b1; r1_addr = 32'h4000_0200;
      grants = 0; exp_port = 0; loops = 0;
      while (grants < 8 && loops < 200) begin
         step();
         loops++;
         r0_req = 1'b0; r1_req = 1'b0; mem_rdy = 1'b0;
         if (r0_rdy && grants < 8) r0_req = 1'b1;
         if (r1_rdy && grants < 8) r1_req = 1'b1;
         if (mem_req) begin
            chk($sformatf("t3_grant%0d_addr", grants), mem_addr,
                (exp_port == 0) ? 32'h4000_0100 : 32'h4000_0200);
            grants++;
            exp_port ^= 1;
            mem_rdy = 1'b1; mem_rdata = 32'(grants);
         end
      end
      chk("t3_grant_count", 32'(grants), 32'd8);
      chk("t3_no_overrun", 32'(overrun), 32'd0);

      // 4. Timeout with TIMEOUT_CYC=4, then mem_rdy on the timeout cycle
      do_reset();
      r0_req = 1'b1; r0_addr = 32'h4000_0010;
      step();
      r0_req = 1'b0;
      step();
      chk("t4_mem_req", 32'(mem_req), 32'd1);
      for (int i = 1; i < 4; i++) begin
         step();
         chk($sformatf("t4_wait%0d_rdy", i), 32'(r0_rdy), 32'd0);
         chk($sformatf("t4_wait%0d_err", i), 32'(err_timeout), 32'd0);
      end
      step();
      chk("t4_to_rdy", 32'(r0_rdy), 32'd1);
      chk("t4_to_rdata", r0_rdata, 32'hDEAD_BEEF);
      chk("t4_to_err", 32'(err_timeout), 32'd1);
      r0_req = 1'b1; r0_addr = 32'h4000_0014;
      step();
      r0_req = 1'b0;
      chk("t4_err_once", 32'(err_timeout), 32'd0);
      step();
      chk("t4b_mem_req", 32'(mem_req), 32'd1);
      step();
      step();
      step();
      mem_rdy = 1'b1; mem_rdata = 32'h5A5A_5A5A;
      step();
      mem_rdy = 1'b0;
      chk("t4b_rdy", 32'(r0_rdy), 32'd1);
      chk("t4b_rdata", r0_rdata, 32'h5A5A_5A5A);
      chk("t4b_no_err", 32'(err_timeout), 32'd0);

      // 5. Overrun on port 1: requests while pending and while in flight
      do_reset();
      r1_req = 1'b1; r1_addr = 32'h4000_3000;
      step();
      r1_addr = 32'h4000_3333;
      step();
      chk("t5_mem_req", 32'(mem_req), 32'd1);
      chk("t5_addr", mem_addr, 32'h4000_3000);
      r1_addr = 32'h4000_4444;
      step();
      r1_req = 1'b0;
      chk("t5_overrun", 32'(overrun), 32'b10);
      mem_rdy = 1'b1; mem_rdata = 32'h0000_0077;
      step();
      mem_rdy = 1'b0;
      chk("t5_r1_rdy", 32'(r1_rdy), 32'd1);
      chk("t5_r1_rdata", r1_rdata, 32'h0000_0077);
      chk("t5_addr_hold", mem_addr, 32'h4000_3000);
      chk("t5_busy", 32'(busy), 32'd0);
      step();
      chk("t5_one_txn_a", 32'(mem_req), 32'd0);
      step();
      chk("t5_one_txn_b", 32'(mem_req), 32'd0);
      arst = 1'b1;
      #1;
      chk("t5_overrun_clr", 32'(overrun), 32'd0);
      step();
      arst = 1'b0;
      step();

      // 6. Reset while in WAIT drops the transaction
      r0_req = 1'b1; r0_addr = 32'h4000_0040;
      step();
      r0_req = 1'b0;
      step();
      chk("t6_mem_req", 32'(mem_req), 32'd1);
      step();
      arst = 1'b1;
      step();
      arst = 1'b0;
      chk("t6_busy_rst", 32'(busy), 32'd0);
      chk("t6_mem_req_rst", 32'(mem_req), 32'd0);
      step();
      mem_rdy = 1'b1; mem_rdata = 32'h0000_0099;
      step();
      mem_rdy = 1'b0;
      chk("t6_r0_rdy", 32'(r0_rdy), 32'd0);
      chk("t6_r1_rdy", 32'(r1_rdy), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_mem_req_after", 32'(mem_req), 32'd0);
      r0_req = 1'b1; r0_addr = 32'h4000_0050;
      step();
      r0_req = 1'b0;
      step();
      chk("t6_new_mem_req", 32'(mem_req), 32'd1);
      chk("t6_new_addr", mem_addr, 32'h4000_0050);
      mem_rdy = 1'b1; mem_rdata = 32'h0BAD_F00D;
      step();
      mem_rdy = 1'b0;
      chk("t6_new_rdy", 32'(r0_rdy), 32'd1);
      chk("t6_new_rdata", r0_rdata, 32'h0BAD_F00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
